// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-setup controllers: widths, engine opcodes, FSM states.
package rsa_pkg;

  localparam int W_DEFAULT = 4096;

  localparam logic OP_R = 1'b0;
  localparam logic OP_T = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    CHK,
    R_GO,
    R_GRD,
    R_WAIT,
    T_GO,
    T_GRD,
    T_WAIT,
    RESP
  } state_t;

  // Round-robin successor of a requester index.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx, input int nreq);
    return (int'(idx) == nreq - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the lowest requesting index at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx,
  output logic            valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!valid && req[(int'(ptr) + k) % NREQ]) begin
          valid = 1'b1;
          grant[(int'(ptr) + k) % NREQ] = 1'b1;
          idx   = 2'((int'(ptr) + k) % NREQ);
        end
      end
    end
  end

endmodule

// File: rtl/rt_param_ctrl.sv
// Shares one rtMod engine between NREQ requesters, producing r = 2^W mod n and t = 2^(2W) mod n.
// Optional one-entry result cache enabled by defining RT_CACHE_EN.
module rt_param_ctrl
  import rsa_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_n,
  output logic            rsp_valid,
  output logic [1:0]      rsp_id,
  output logic            rsp_err,
  output logic [W-1:0]    rsp_r,
  output logic [W-1:0]    rsp_t,
  output logic            busy,
  output logic            eng_go,
  output logic            eng_mode,
  output logic [W-1:0]    eng_n,
  input  logic [W-1:0]    eng_r,
  input  logic            eng_done
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state, next_state;
  logic [1:0]        ptr;
  logic [NREQ-1:0]   gnt, gnt_q, mask;
  logic [1:0]        gnt_idx;
  logic              gnt_valid;
  logic [CNT_W-1:0]  cnt;
  logic              tmo, n_zero, cache_hit, launch;

  // The winner's request is masked for the cycle after RESP while it drops req_valid.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid & ~mask),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  assign tmo    = (cnt == CNT_LAST);
  assign n_zero = (eng_n == '0);
  assign launch = (next_state == R_GO) || (next_state == T_GO);

`ifdef RT_CACHE_EN
  logic          cache_valid;
  logic [W-1:0]  cache_n, cache_r, cache_t;

  assign cache_hit = cache_valid && (eng_n == cache_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cache_valid <= 1'b0;
    else if (state == RESP)  cache_valid <= !rsp_err;
  end

  // NOTE: the wide payload carries no reset; cache_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (state == RESP && !rsp_err) begin
      cache_n <= eng_n;
      cache_r <= rsp_r;
      cache_t <= rsp_t;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (gnt_valid) next_state = CHK;
      CHK:     next_state = (n_zero || cache_hit) ? RESP : R_GO;
      R_GO:    next_state = R_GRD;
      R_GRD:   next_state = R_WAIT;
      R_WAIT:  if (eng_done) next_state = T_GO;
               else if (tmo) next_state = RESP;
      T_GO:    next_state = T_GRD;
      T_GRD:   next_state = T_WAIT;
      T_WAIT:  if (eng_done || tmo) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_go    <= 1'b0;
      eng_mode  <= OP_R;
      eng_n     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_r     <= '0;
      rsp_t     <= '0;
      busy      <= 1'b0;
      ptr       <= '0;
      gnt_q     <= '0;
      mask      <= '0;
      cnt       <= '0;
    end else begin
      eng_go    <= launch;
      rsp_valid <= (next_state == RESP);
      busy      <= (next_state != IDLE);
      mask      <= (state == RESP) ? gnt_q : '0;
      cnt       <= launch ? '0 : cnt + 1'b1;
      if (next_state == R_GO) eng_mode <= OP_R;
      if (next_state == T_GO) eng_mode <= OP_T;

      unique case (state)
        IDLE: if (gnt_valid) begin
          eng_n   <= req_n[int'(gnt_idx)*W +: W];
          rsp_id  <= gnt_idx;
          rsp_err <= 1'b0;
          gnt_q   <= gnt;
          ptr     <= next_ptr(gnt_idx, NREQ);
        end
        CHK: begin
          if (n_zero) rsp_err <= 1'b1;
`ifdef RT_CACHE_EN
          else if (cache_hit) begin
            rsp_r <= cache_r;
            rsp_t <= cache_t;
          end
`endif
        end
        R_WAIT: begin
          if (eng_done) rsp_r   <= eng_r;
          else if (tmo) rsp_err <= 1'b1;
        end
        T_WAIT: begin
          if (eng_done) rsp_t   <= eng_r;
          else if (tmo) rsp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
